// File: rtl/ssp_pkg.sv
// Shared types and constants for the SSP receive path.
package ssp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PUSH  = 2'd2,
        HOLD  = 2'd3
    } ssp_state_t;

    localparam int SSP_DATA_WIDTH     = 8;
    localparam int SSP_MIN_SCLK_RATIO = 4;

endpackage

// File: rtl/ssp_sync_edge.sv
// Multi-flop synchronizer for the serial pins, with rising-edge detect on bit 0 (the serial clock).
module ssp_sync_edge #(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_sync,
    output logic             o_rise
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic             r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= r_sync[SYNC_STAGES-1][0];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = o_sync[0] & ~r_prev;

endmodule

// File: rtl/ssp_rx_ctrl.sv
// SSP receive sequencer: deserializes MSB-first frames and pushes them to the RxFIFO.
// Optional SSP_RX_OVR_COUNT_EN adds a saturating dropped-frame counter output.
//
//   state | meaning
//   IDLE  | waiting for frame sync on a serial clock rise
//   SHIFT | capturing data bits
//   PUSH  | word complete, write it unless the FIFO is full
//   HOLD  | word parked until the FIFO has room; new frames are dropped
module ssp_rx_ctrl
    import ssp_pkg::*;
#(
    parameter int DATA_WIDTH  = SSP_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  PCLK,
    input  logic                  CLEAR_B,
    input  logic                  SSPCLKIN,
    input  logic                  SSPFSSIN,
    input  logic                  SSPRXD,
    input  logic                  fifo_full,
    input  logic                  ovr_clr,
    output logic [DATA_WIDTH-1:0] RxData,
    output logic                  write_ready,
    output logic                  rx_busy,
    output logic                  rx_overrun
`ifdef SSP_RX_OVR_COUNT_EN
    ,
    output logic [7:0]            ovr_count
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    ssp_state_t             r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0]  r_shreg, w_shreg_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0]  r_rxdata;
    logic                   r_wr, r_busy, r_ovr;
    logic                   w_push, w_ovr_set;
    logic [2:0]             w_sync;
    logic                   w_rise, w_start;

    // bit 0 = serial clock, bit 1 = frame sync, bit 2 = data
    ssp_sync_edge #(
        .WIDTH       (3),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (PCLK),
        .i_rst_n (CLEAR_B),
        .i_d     ({SSPRXD, SSPFSSIN, SSPCLKIN}),
        .o_sync  (w_sync),
        .o_rise  (w_rise)
    );

    assign w_start = w_rise & w_sync[1];

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        w_ovr_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = SHIFT;
                    w_cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (w_start) begin
                    w_cnt_nxt = '0;
                end else if (w_rise) begin
                    w_shreg_nxt = {r_shreg[DATA_WIDTH-2:0], w_sync[2]};
                    w_cnt_nxt   = r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) w_state_nxt = PUSH;
                end
            end
            PUSH: begin
                if (fifo_full) begin
                    w_state_nxt = HOLD;
                end else begin
                    w_push = 1'b1;
                    if (w_start) begin
                        w_state_nxt = SHIFT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            HOLD: begin
                // a frame starting while a word is parked here is lost
                if (w_start) w_ovr_set = 1'b1;
                if (!fifo_full) begin
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_rxdata <= '0;
            r_wr     <= 1'b0;
            r_busy   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wr    <= w_push;
            r_busy  <= (r_state != IDLE);
            if (w_push) r_rxdata <= r_shreg;
            if (w_ovr_set)    r_ovr <= 1'b1;
            else if (ovr_clr) r_ovr <= 1'b0;
        end
    end

`ifdef SSP_RX_OVR_COUNT_EN
    logic [7:0] r_ovr_cnt;

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            r_ovr_cnt <= '0;
        end else if (w_ovr_set) begin
            if (r_ovr_cnt != 8'hFF) r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end else if (ovr_clr) begin
            r_ovr_cnt <= '0;
        end
    end

    assign ovr_count = r_ovr_cnt;
`endif

    assign RxData      = r_rxdata;
    assign write_ready = r_wr;
    assign rx_busy     = r_busy;
    assign rx_overrun  = r_ovr;

endmodule

// File: doc/ssp_rx_ctrl.md
Name: ssp_rx_ctrl

Overview:
Receive-side sequencer for the SSP. Samples the external serial receive interface in the PCLK domain and deserializes 8-bit frames. Writes each completed word into the receive FIFO with a one-cycle write_ready pulse, stalling on FIFO-full and flagging overrun when a frame arrives that cannot be buffered. Sits between the SSP pins and the RxFIFO RxData/write_ready/SSPRXINTR interface.

Parameters:
DATA_WIDTH, 8, frame and RxData width
SYNC_STAGES, 2, synchronizer flops per serial input (minimum 2)

Ports:
PCLK  input  1  system clock
CLEAR_B  input  1  asynchronous active-low reset
SSPCLKIN  input  1  external serial clock; period at least 4*(SYNC_STAGES+1) PCLK cycles
SSPFSSIN  input  1  frame sync; high for one serial clock before bit 0
SSPRXD  input  1  serial data, MSB first
fifo_full  input  1  RxFIFO full (SSPRXINTR)
ovr_clr  input  1  single-cycle pulse that clears rx_overrun
RxData  output  DATA_WIDTH  word presented to the FIFO
write_ready  output  1  one-cycle FIFO write strobe
rx_busy  output  1  high when the state machine is not in IDLE
rx_overrun  output  1  sticky flag: a frame was dropped

Behaviour:
- Reset: CLEAR_B low asynchronously clears all flops.
  - State=IDLE, RxData=0, write_ready=0, rx_busy=0, rx_overrun=0.
  - Synchronizers, shift register and bit counter also clear to 0.
- SSPCLKIN, SSPFSSIN and SSPRXD each pass through SYNC_STAGES flops.
  - sclk_rise = synced clock high AND its previous registered value low.
  - All serial sampling happens only on cycles where sclk_rise is high.
- IDLE: on sclk_rise with synced FSS=1, go to SHIFT and set bit_cnt=0.
- SHIFT: on each sclk_rise, shreg = {shreg[DATA_WIDTH-2:0], rxd} and bit_cnt increments.
  - When the DATA_WIDTH-th bit is captured, go to PUSH.
  - FSS=1 on an sclk_rise in SHIFT restarts the frame: bit_cnt=0, partial word discarded, no overrun.
- PUSH, fifo_full=0: register RxData=shreg, write_ready=1 for exactly one cycle, go to IDLE.
  - If sclk_rise with FSS=1 in the same cycle, go to SHIFT instead of IDLE.
- PUSH, fifo_full=1: go to HOLD and keep the word in shreg. write_ready stays 0.
- HOLD: the first cycle with fifo_full=0 issues the RxData/write_ready pulse and goes to IDLE.
  - sclk_rise with FSS=1 while in HOLD sets rx_overrun.
  - The held (older) word is kept. The new frame is ignored entirely and the state stays HOLD.
- write_ready is never asserted while fifo_full=1, so the FIFO's write qualifier never rejects a word.
- RxData holds the last pushed value between pushes.
- Latency (SYNC_STAGES=2, FIFO not full):
  - Edge 1: first PCLK edge that samples the pin SSPCLKIN high for the last bit.
  - write_ready is high in the cycle after edge 4.
  - General case: SYNC_STAGES+2 edges.
- rx_overrun: sticky until ovr_clr. If set and ovr_clr occur in the same cycle, set wins.
- rx_busy is a registered decode (state != IDLE).

Optional Feature:
SSP_RX_OVR_COUNT_EN:
- Defined: adds output ovr_count[7:0].
  - Increments on each dropped frame and saturates at 8'hFF.
  - Cleared by ovr_clr; increment wins if both occur in the same cycle.
  - Reset value 0.
- Undefined: the port and counter are absent; rx_overrun behaviour is unchanged.

Decomposition:
- Package ssp_pkg holds:
  - state enum {IDLE, SHIFT, PUSH, HOLD}, 2-bit encoding 0..3.
  - SSP_DATA_WIDTH=8 and SSP_MIN_SCLK_RATIO=4.
- Sub-module ssp_sync_edge: SYNC_STAGES synchronizer plus rising-edge detect, used for SSPCLKIN.
- FSS and RXD use the same sub-module's synchronized output, with the edge output unused.

Test Plan:
1. Frame 0xA5, fifo_full=0 -> exactly one write_ready pulse with RxData=0xA5. rx_busy returns to 0 the next cycle.
2. Back-to-back frames 0x3C then 0xC3, with FSS on the serial clock right after bit 7 -> two pulses in order carrying 0x3C and 0xC3, no overrun.
3. fifo_full=1 when frame 0x5A completes -> no pulse and state HOLD. Drop fifo_full after 10 cycles -> pulse with RxData=0x5A on the first cycle full is low.
4. Hold 0x5A with full=1, then send frame 0xFF -> rx_overrun=1 (ovr_count=1 if enabled). Release full -> only 0x5A is written. ovr_clr -> rx_overrun=0.
5. CLEAR_B low after 4 bits of 0x81 -> all outputs 0 immediately, without waiting for a PCLK edge. After release, a full frame 0x81 gives one pulse with RxData=0x81.
6. FSS reasserted after 3 bits, then frame 0x96 -> single pulse with RxData=0x96, rx_overrun stays 0.
